// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with a two-state handshake to a variable-latency data memory.
// Memory ops freeze upstream until Mem_Ack; ALU results pass through in one cycle.
module mem_wb_stage #(
    parameter logic [31:0] MEM_BASE = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_En_In,
    input  logic        Mem_R_En_In,
    input  logic        Mem_W_En_In,
    input  logic [3:0]  Dest_In,
    input  logic [31:0] ALU_Res_In,
    input  logic [31:0] Val_Rm_In,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_Wdata,
    input  logic [31:0] Mem_Rdata,
    input  logic        Mem_Ack,
    output logic        Freeze,
    output logic        WB_En_Out,
    output logic        Mem_R_En_Out,
    output logic [3:0]  Dest_Out,
    output logic [31:0] ALU_Res_Out,
    output logic [31:0] Mem_Data_Out
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d, wb_q, wb_d, mr_q, mr_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, alu_q, alu_d, data_q, data_d;
    logic [3:0]  dest_q, dest_d;
    logic        op, start, done, load;

    always_comb begin
        op      = Mem_R_En_In | Mem_W_En_In;
        start   = (state_q == IDLE) && op;
        done    = (state_q == WAIT) && Mem_Ack;
        load    = ((state_q == IDLE) && !op) || done;
        Freeze  = start || ((state_q == WAIT) && !Mem_Ack);
        state_d = start ? WAIT : done ? IDLE : state_q;
        req_d   = start ? 1'b1 : done ? 1'b0 : req_q;
        we_d    = start ? Mem_W_En_In : done ? 1'b0 : we_q;
        addr_d  = start ? (ALU_Res_In - MEM_BASE) >> 2 : addr_q;
        wdata_d = start ? Val_Rm_In : wdata_q;
        // Anything other than a real load is a bubble: control bits cleared, payload kept.
        wb_d    = load & WB_En_In;
        mr_d    = done & Mem_R_En_In;
        dest_d  = load ? Dest_In : dest_q;
        alu_d   = load ? ALU_Res_In : alu_q;
        data_d  = done ? (Mem_W_En_In ? 32'd0 : Mem_Rdata) : load ? 32'd0 : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wb_q    <= 1'b0;
            mr_q    <= 1'b0;
            dest_q  <= '0;
            alu_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wb_q    <= wb_d;
            mr_q    <= mr_d;
            dest_q  <= dest_d;
            alu_q   <= alu_d;
            data_q  <= data_d;
        end
    end

    assign Mem_Req      = req_q;
    assign Mem_We       = we_q;
    assign Mem_Addr     = addr_q;
    assign Mem_Wdata    = wdata_q;
    assign WB_En_Out    = wb_q;
    assign Mem_R_En_Out = mr_q;
    assign Dest_Out     = dest_q;
    assign ALU_Res_Out  = alu_q;
    assign Mem_Data_Out = data_q;
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter MEM_BASE, default 32'd1024, byte address of data-memory word 0.
REQ-002 Port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Ports WB_En_In, Mem_R_En_In, Mem_W_En_In  input  1 each  control bits from the EX/MEM register.
REQ-005 Port Dest_In  input  4  destination register index.
REQ-006 Ports ALU_Res_In, Val_Rm_In  input  32 each  byte address or ALU result; store data.
REQ-007 Ports Mem_Req, Mem_We  output  1 each  memory request and write-enable, both registered.
REQ-008 Ports Mem_Addr, Mem_Wdata  output  32 each  word address and store data, both registered.
REQ-009 Ports Mem_Rdata  input  32  read data; Mem_Ack  input  1  completion strobe, valid only while Mem_Req=1.
REQ-010 Port Freeze  output  1  combinational stall to the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-011 Ports WB_En_Out, Mem_R_En_Out  output  1 each; Dest_Out  output  4; ALU_Res_Out, Mem_Data_Out  output  32 each  MEM/WB register.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-013 op = Mem_R_En_In | Mem_W_En_In; if both are 1, the access SHALL be a write.
REQ-014 IDLE, op=0: on the next edge, MEM/WB SHALL load WB_En_In, 0, Dest_In, ALU_Res_In, 0; state stays IDLE (1-cycle latency).
REQ-015 IDLE, op=1: on the next edge, state SHALL go to WAIT and Mem_Req SHALL go to 1.
REQ-016 On that same edge, Mem_We SHALL load Mem_W_En_In, Mem_Addr SHALL load (ALU_Res_In - MEM_BASE) >> 2 (32-bit modulo, logical shift), and Mem_Wdata SHALL load Val_Rm_In.
REQ-017 On that same edge, MEM/WB SHALL load a bubble: WB_En_Out=0, Mem_R_En_Out=0, other fields unchanged.
REQ-018 WAIT, Mem_Ack=0: Mem_Req, Mem_We, Mem_Addr and Mem_Wdata SHALL hold; MEM/WB SHALL load a bubble each edge.
REQ-019 WAIT, Mem_Ack=1: on the next edge, state SHALL go to IDLE, Mem_Req to 0 and Mem_We to 0.
REQ-020 On that same edge, MEM/WB SHALL load WB_En_In, Mem_R_En_In, Dest_In and ALU_Res_In, and Mem_Data_Out SHALL load Mem_Rdata for reads or 0 for writes.
REQ-021 Freeze SHALL be 1 when (IDLE and op=1) or (WAIT and Mem_Ack=0), and 0 otherwise; it SHALL be 0 in the Mem_Ack cycle so upstream advances on the completing edge.
REQ-022 Mem_Ack while in IDLE SHALL be ignored.
REQ-023 Upstream inputs SHALL be held stable by Freeze throughout WAIT; the block SHALL NOT re-register them mid-access.
REQ-024 Memory-op latency SHALL be 2 + N cycles from op presentation to MEM/WB load, where N = the number of WAIT cycles with Mem_Ack=0.
REQ-025 Back-to-back memory ops SHALL each re-enter WAIT with no lost or duplicated request; Mem_Req SHALL drop for at least one cycle between them.

Reset
REQ-026 Asserting rst SHALL force state to IDLE and set every output register to 0: Mem_Req, Mem_We, Mem_Addr, Mem_Wdata and all MEM/WB fields.
REQ-027 Reset asserted during WAIT SHALL abort the access immediately (Mem_Req=0 without waiting for Mem_Ack), and no MEM/WB write SHALL result from it.
REQ-028 While rst=1, Freeze SHALL follow REQ-021 with state=IDLE.

Verification
REQ-029 ALU op: WB_En_In=1, Dest_In=5, ALU_Res_In=0x1234, no op -> next edge WB_En_Out=1, Dest_Out=5, ALU_Res_Out=0x1234; Freeze stays 0; Mem_Req stays 0.
REQ-030 Load, 0 wait: Mem_R_En_In=1, ALU_Res_In=1032, Mem_Ack=1 in the first WAIT cycle with Mem_Rdata=0xDEADBEEF -> Mem_Addr=2; Freeze high 1 cycle; Mem_Data_Out=0xDEADBEEF and Mem_R_En_Out=1 two edges after presentation.
REQ-031 Store, 3 waits: Mem_W_En_In=1, ALU_Res_In=1024, Val_Rm_In=7; Mem_Ack after 3 low cycles -> Mem_We=1, Mem_Addr=0, Mem_Wdata=7 held for 4 cycles; Freeze high 4 cycles; MEM/WB WB_En_Out=0, Mem_Data_Out=0.
REQ-032 Back-to-back load then store, each acked in the first WAIT cycle -> two separate Mem_Req pulses with a 1-cycle gap; each MEM/WB result appears exactly once.
REQ-033 Reset mid-WAIT: assert rst two cycles into a load -> Mem_Req=0 and all outputs 0 asynchronously; after release, an ALU op passes per REQ-029.
REQ-034 Stray Mem_Ack pulse in IDLE with op=0 -> no state change, Mem_Req stays 0, Mem_Data_Out stays 0.
